// File: rtl/intersection_controller_if.sv
// Signal bundle between the timing-config registers, the intersection controller and the display drivers.
interface intersection_controller_if #(
   parameter int unsigned NUM_PHASES = 2,
   parameter int unsigned TW         = 11,
   parameter int unsigned CW         = 9,
   parameter int unsigned PW         = 1
);
   logic [TW-1:0]            gLength;
   logic [TW-1:0]            yLength;
   logic [TW-1:0]            arLength;
   logic [TW-1:0]            walkLength;
   logic [NUM_PHASES-1:0]    walkReq;
   logic [NUM_PHASES-1:0]    carSense;
   logic                     clearCounts;
   logic [2*NUM_PHASES-1:0]  light;
   logic [PW-1:0]            phaseIdx;
   logic                     walkLight;
   logic [CW*NUM_PHASES-1:0] carCount;
   logic [CW-1:0]            walkCount;

   modport master (
      output gLength, yLength, arLength, walkLength, walkReq, carSense, clearCounts,
      input  light, phaseIdx, walkLight, carCount, walkCount
   );

   modport slave (
      input  gLength, yLength, arLength, walkLength, walkReq, carSense, clearCounts,
      output light, phaseIdx, walkLight, carCount, walkCount
   );
endinterface

// File: rtl/intersection_controller.sv
// Round-robin multi-approach traffic controller: GREEN -> YELLOW -> ALLRED per approach,
// with an all-red WALK interval inserted after ALLRED whenever a pedestrian request is pending.
module intersection_controller #(
   parameter int unsigned NUM_PHASES = 2,
   parameter int unsigned TW         = 11,
   parameter int unsigned CW         = 9,
   parameter int unsigned PW         = 1
) (
   input logic                      clock,
   input logic                      reset,
   intersection_controller_if.slave bus
);
   localparam int unsigned LW = 2 * NUM_PHASES;
   localparam int unsigned KW = CW * NUM_PHASES;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {S_INIT, S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;

   state_t                state, state_nxt;
   logic [PW-1:0]         phase, phase_nxt;
   logic [TW-1:0]         timer, len_nxt;
   logic                  enter, walk_entry;
   logic [NUM_PHASES-1:0] pending, car_inc;
   logic [LW-1:0]         light;
   logic                  walk_light;
   logic [KW-1:0]         car_cnt;
   logic [CW-1:0]         walk_cnt;

   // Zero-length intervals behave as one cycle.
   function automatic logic [TW-1:0] load_of(input logic [TW-1:0] len);
      return (len == '0) ? '0 : TW'(len - TW'(1));
   endfunction

   function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] p);
      return (32'(p) == NUM_PHASES - 1) ? '0 : PW'(p + PW'(1));
   endfunction

   function automatic logic [LW-1:0] lamp(input state_t s, input logic [PW-1:0] p);
      logic [LW-1:0] l;
      l = '0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (PW'(i) == p) begin
            if (s == S_GREEN)       l[2*i +: 2] = 2'b11;
            else if (s == S_YELLOW) l[2*i +: 2] = 2'b01;
         end
      end
      return l;
   endfunction

   // Next-state decode; a state exits in the cycle its timer reads zero.
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      len_nxt   = '0;
      enter     = 1'b0;
      if (state == S_INIT) begin
         state_nxt = S_GREEN;
         phase_nxt = '0;
         len_nxt   = bus.gLength;
         enter     = 1'b1;
      end else if (timer == '0) begin
         enter = 1'b1;
         case (state)
            S_GREEN: begin
               state_nxt = S_YELLOW;
               len_nxt   = bus.yLength;
            end
            S_YELLOW: begin
               state_nxt = S_ALLRED;
               len_nxt   = bus.arLength;
            end
            S_ALLRED: begin
               if (|pending) begin
                  state_nxt = S_WALK;
                  len_nxt   = bus.walkLength;
               end else begin
                  state_nxt = S_GREEN;
                  phase_nxt = next_phase(phase);
                  len_nxt   = bus.gLength;
               end
            end
            default: begin
               state_nxt = S_GREEN;
               phase_nxt = next_phase(phase);
               len_nxt   = bus.gLength;
            end
         endcase
      end
      walk_entry = enter && (state_nxt == S_WALK);
      for (int p = 0; p < NUM_PHASES; p++) begin
         car_inc[p] = bus.carSense[p] && (phase == PW'(p)) &&
                      ((state == S_GREEN) || (state == S_YELLOW));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_INIT;
         phase      <= '0;
         timer      <= '0;
         pending    <= '0;
         light      <= '0;
         walk_light <= 1'b0;
         car_cnt    <= '0;
         walk_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         timer      <= enter ? load_of(len_nxt) : TW'(timer - TW'(1));
         light      <= lamp(state_nxt, phase_nxt);
         walk_light <= (state_nxt == S_WALK);

         // Requests are ignored while walking and in the cycle that starts the walk.
         if (walk_entry)          pending <= '0;
         else if (state != S_WALK) pending <= pending | bus.walkReq;

         if (bus.clearCounts)
            walk_cnt <= '0;
         else if (walk_entry && (walk_cnt != CNT_MAX))
            walk_cnt <= walk_cnt + CW'(1);

         for (int p = 0; p < NUM_PHASES; p++) begin
            if (bus.clearCounts)
               car_cnt[p*CW +: CW] <= '0;
            else if (car_inc[p] && (car_cnt[p*CW +: CW] != CNT_MAX))
               car_cnt[p*CW +: CW] <= car_cnt[p*CW +: CW] + CW'(1);
         end
      end
   end

   assign bus.light     = light;
   assign bus.phaseIdx  = phase;
   assign bus.walkLight = walk_light;
   assign bus.carCount  = car_cnt;
   assign bus.walkCount = walk_cnt;
endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: directed scenarios plus random traffic against a cycle model.
module tb_intersection_controller;
   localparam int NP   = 2;
   localparam int CMAX = 511;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   intersection_controller_if #(.NUM_PHASES(2), .TW(8), .CW(9), .PW(1)) bus ();

   intersection_controller #(.NUM_PHASES(2), .TW(8), .CW(9), .PW(1)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: kind 0 init, 1 green, 2 yellow, 3 all-red, 4 walk; m_left = cycles left incl. current.
   int       m_st, m_ph, m_left, m_walk;
   int       m_car [NP];
   bit [1:0] m_pend;
   logic [3:0] tab_light [9];
   logic       tab_phase [9];

   task automatic model_reset();
      m_st = 0; m_ph = 0; m_left = 1; m_walk = 0; m_pend = '0;
      for (int p = 0; p < NP; p++) m_car[p] = 0;
   endtask

   function automatic int len_of(input int s);
      int l;
      case (s)
         1: l = int'(bus.gLength);
         2: l = int'(bus.yLength);
         3: l = int'(bus.arLength);
         default: l = int'(bus.walkLength);
      endcase
      return (l < 1) ? 1 : l;
   endfunction

   task automatic model_edge();
      int nst, nph;
      bit entering;
      if (!reset) begin
         model_reset();
         return;
      end
      nst = m_st; nph = m_ph; entering = 0;
      if (m_st == 0) begin
         nst = 1; nph = 0; entering = 1;
      end else if (m_left == 1) begin
         entering = 1;
         case (m_st)
            1: nst = 2;
            2: nst = 3;
            3: if (m_pend != 0) nst = 4; else begin nst = 1; nph = (m_ph + 1) % NP; end
            default: begin nst = 1; nph = (m_ph + 1) % NP; end
         endcase
      end else begin
         m_left--;
      end
      for (int p = 0; p < NP; p++) begin
         if (bus.clearCounts) m_car[p] = 0;
         else if ((m_st == 1 || m_st == 2) && m_ph == p && bus.carSense[p] && m_car[p] < CMAX)
            m_car[p]++;
      end
      if (bus.clearCounts) m_walk = 0;
      else if (entering && nst == 4 && m_walk < CMAX) m_walk++;
      if (entering && nst == 4) m_pend = '0;
      else if (m_st != 4) m_pend |= bus.walkReq;
      if (entering) m_left = len_of(nst);
      m_st = nst; m_ph = nph;
   endtask

   function automatic logic [3:0] exp_light();
      logic [3:0] l;
      l = '0;
      if (m_st == 1)      l[2*m_ph +: 2] = 2'b11;
      else if (m_st == 2) l[2*m_ph +: 2] = 2'b01;
      return l;
   endfunction

   function automatic logic [17:0] exp_cars();
      return {9'(m_car[1]), 9'(m_car[0])};
   endfunction

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic set_defaults();
      bus.gLength = 8'd3; bus.yLength = 8'd2; bus.arLength = 8'd1; bus.walkLength = 8'd2;
      bus.walkReq = '0; bus.carSense = '0; bus.clearCounts = 1'b0;
   endtask

   task automatic restart();
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_defaults();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      total++;
      if (bus.light !== 4'h0 || bus.phaseIdx !== 1'b0 || bus.walkLight !== 1'b0 ||
          bus.carCount !== 18'h0 || bus.walkCount !== 9'h0) begin
         bad++;
         $display("FAIL reset_state: light=%b phase=%b walk=%b cars=%h walks=%0d want all zero",
                  bus.light, bus.phaseIdx, bus.walkLight, bus.carCount, bus.walkCount);
      end
      @(negedge clock);
      reset = 1'b1;
      tab_light = '{4'h3, 4'h3, 4'h3, 4'h1, 4'h1, 4'h0, 4'hC, 4'hC, 4'hC};
      tab_phase = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      total++;
      if (bus.light !== 4'h0) begin
         bad++;
         $display("FAIL init_cycle light: got %b want 0000", bus.light);
      end
      for (int c = 1; c <= 9; c++) begin
         tick();
         total++;
         if (bus.light !== tab_light[c-1] || bus.phaseIdx !== tab_phase[c-1]) begin
            bad++;
            $display("FAIL sequence c%0d: light=%b phase=%b want %b %b",
                     c, bus.light, bus.phaseIdx, tab_light[c-1], tab_phase[c-1]);
         end
      end
   endtask

   task automatic test_short_intervals();
      int gcyc, ycyc;
      set_defaults();
      bus.yLength = 8'd0; bus.arLength = 8'd0;
      restart();
      gcyc = 0; ycyc = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (bus.light == 4'h3 || bus.light == 4'hC) gcyc++;
         if (bus.light == 4'h1 || bus.light == 4'h4) ycyc++;
         total++;
         if (bus.light !== exp_light() || bus.phaseIdx !== 1'(m_ph)) begin
            bad++;
            $display("FAIL short c%0d: light=%b phase=%b want %b %0d", c, bus.light, bus.phaseIdx, exp_light(), m_ph);
         end
      end
      total++;
      if (gcyc != 12 || ycyc != 4) begin
         bad++;
         $display("FAIL short_durations: green=%0d yellow=%0d want 12 4", gcyc, ycyc);
      end
   endtask

   task automatic test_walk();
      set_defaults();
      restart();
      tick();
      bus.walkReq = 2'b10;
      tick();
      bus.walkReq = 2'b00;
      for (int c = 3; c <= 11; c++) begin
         tick();
         total++;
         if (bus.light !== exp_light() || bus.walkLight !== (m_st == 4) || bus.walkCount !== 9'(m_walk)) begin
            bad++;
            $display("FAIL walk_pulse c%0d: light=%b walk=%b walks=%0d want %b %0d %0d",
                     c, bus.light, bus.walkLight, bus.walkCount, exp_light(), m_st == 4, m_walk);
         end
         if (c == 7 || c == 8) begin
            total++;
            if (bus.walkLight !== 1'b1 || bus.light !== 4'h0) begin
               bad++;
               $display("FAIL walk_interval c%0d: walk=%b light=%b want 1 0000", c, bus.walkLight, bus.light);
            end
         end
         if (c == 9) begin
            total++;
            if (bus.phaseIdx !== 1'b1 || bus.walkCount !== 9'd1 || bus.light !== 4'hC) begin
               bad++;
               $display("FAIL walk_exit: phase=%b walks=%0d light=%b want 1 1 1100",
                        bus.phaseIdx, bus.walkCount, bus.light);
            end
         end
      end
      // A request held across the whole walk must not start a second one.
      restart();
      bus.walkReq = 2'b01;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 9) bus.walkReq = 2'b00;
         total++;
         if (bus.walkLight !== ((c == 7) || (c == 8)) || bus.light !== exp_light()) begin
            bad++;
            $display("FAIL walk_held c%0d: walk=%b light=%b want %b %b",
                     c, bus.walkLight, bus.light, (c == 7) || (c == 8), exp_light());
         end
      end
      total++;
      if (bus.walkCount !== 9'd1) begin
         bad++;
         $display("FAIL walk_held_count: got %0d want 1", bus.walkCount);
      end
   endtask

   task automatic test_cars();
      set_defaults();
      bus.carSense = 2'b11;
      restart();
      for (int c = 1; c <= 12; c++) begin
         tick();
         total++;
         if (bus.carCount !== exp_cars()) begin
            bad++;
            $display("FAIL cars c%0d: got %h want %h", c, bus.carCount, exp_cars());
         end
         if (c == 6) begin
            total++;
            if (bus.carCount !== {9'd0, 9'd5}) begin
               bad++;
               $display("FAIL cars_phase0: got %h want %h", bus.carCount, {9'd0, 9'd5});
            end
         end
      end
      total++;
      if (bus.carCount !== {9'd5, 9'd5}) begin
         bad++;
         $display("FAIL cars_phase1: got %h want %h", bus.carCount, {9'd5, 9'd5});
      end
   endtask

   task automatic test_saturation();
      set_defaults();
      bus.gLength = 8'd200; bus.yLength = 8'd200;
      bus.carSense = 2'b01;
      restart();
      for (int c = 1; c <= 952; c++) begin
         tick();
         if (c == 951) bus.clearCounts = 1'b0;
         if ((c % 50) == 0 || c >= 945) begin
            total++;
            if (bus.carCount !== exp_cars()) begin
               bad++;
               $display("FAIL sat_track c%0d: got %h want %h", c, bus.carCount, exp_cars());
            end
         end
         if (c == 950) begin
            total++;
            if (bus.carCount[8:0] !== 9'd511) begin
               bad++;
               $display("FAIL sat_ceiling: got %0d want 511", bus.carCount[8:0]);
            end
            bus.clearCounts = 1'b1;
         end
         if (c == 951) begin
            total++;
            if (bus.carCount[8:0] !== 9'd0) begin
               bad++;
               $display("FAIL clear_wins: got %0d want 0", bus.carCount[8:0]);
            end
         end
      end
      total++;
      if (bus.carCount[8:0] !== 9'd1) begin
         bad++;
         $display("FAIL after_clear: got %0d want 1", bus.carCount[8:0]);
      end
   endtask

   task automatic test_random();
      set_defaults();
      restart();
      for (int c = 1; c <= 2000; c++) begin
         tick();
         if ($urandom_range(0, 7) == 0) bus.gLength    = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 7) == 0) bus.yLength    = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 7) == 0) bus.arLength   = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) bus.walkLength = 8'($urandom_range(0, 4));
         bus.walkReq     = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         bus.carSense    = 2'($urandom_range(0, 3));
         bus.clearCounts = ($urandom_range(0, 63) == 0);
         total++;
         if (bus.light !== exp_light() || bus.phaseIdx !== 1'(m_ph) || bus.walkLight !== (m_st == 4) ||
             bus.carCount !== exp_cars() || bus.walkCount !== 9'(m_walk)) begin
            bad++;
            $display("FAIL random c%0d: light=%b phase=%b walk=%b cars=%h walks=%0d want %b %0d %0d %h %0d",
                     c, bus.light, bus.phaseIdx, bus.walkLight, bus.carCount, bus.walkCount,
                     exp_light(), m_ph, m_st == 4, exp_cars(), m_walk);
         end
      end
   endtask

   task automatic test_async_reset();
      set_defaults();
      bus.carSense = 2'b11;
      restart();
      repeat (4) tick();
      total++;
      if (bus.light !== 4'h1 || bus.carCount[8:0] !== 9'd3) begin
         bad++;
         $display("FAIL pre_reset: light=%b lane0=%0d want 0001 3", bus.light, bus.carCount[8:0]);
      end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      total++;
      if (bus.light !== 4'h0 || bus.carCount !== 18'h0 || bus.phaseIdx !== 1'b0 || bus.walkCount !== 9'h0) begin
         bad++;
         $display("FAIL async_reset: light=%b cars=%h phase=%b walks=%0d want zeros",
                  bus.light, bus.carCount, bus.phaseIdx, bus.walkCount);
      end
      @(negedge clock);
      reset = 1'b1;
      bus.carSense = 2'b00;
      for (int c = 1; c <= 9; c++) begin
         tick();
         total++;
         if (bus.light !== tab_light[c-1] || bus.phaseIdx !== tab_phase[c-1] || bus.light !== exp_light()) begin
            bad++;
            $display("FAIL restart_seq c%0d: light=%b phase=%b want %b %b",
                     c, bus.light, bus.phaseIdx, tab_light[c-1], tab_phase[c-1]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_short_intervals();
      test_walk();
      test_cars();
      test_saturation();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
